calc_op_ctrl: RTL and testbench

- Operation sequencer for the calculator datapath.
- Accepts one operation request from the keypad/decoder.
- Drives the shared x register's mode-select lines (from_mul/from_div/from_sqr) and issues a start pulse to the selected unit (ALU, multiplier, divider, square-root).
- Waits for that unit's done, then reports completion and the result-source select to the display path.

---
 rtl/calc_op_ctrl_pkg.sv | 36 +++
 rtl/calc_op_ctrl_if.sv | 35 +++
 rtl/calc_op_ctrl_watchdog.sv | 30 +++
 rtl/calc_op_ctrl.sv | 143 ++++++++++++++
 tb/tb_calc_op_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_op_ctrl_pkg.sv
// Shared calculator definitions: op codes, x-register mode selects and sequencer states.
// The mode-select constants are also used by the x register itself.
package calc_pkg;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SQR = 2'b11;

    localparam logic [2:0] SEL_ALU = 3'b000;
    localparam logic [2:0] SEL_MUL = 3'b100;
    localparam logic [2:0] SEL_DIV = 3'b010;
    localparam logic [2:0] SEL_SQR = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_LOAD = 3'd2,
        ST_GO   = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic [2:0] sel_of_op(input logic [1:0] op);
        logic [2:0] sel;
        sel = SEL_ALU;
        case (op)
            OP_MUL:  sel = SEL_MUL;
            OP_DIV:  sel = SEL_DIV;
            OP_SQR:  sel = SEL_SQR;
            default: sel = SEL_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/calc_op_ctrl_if.sv
// Request/strobe/completion bundle between the keypad decoder, the arithmetic units and the sequencer.
// slave is the sequencer side; master is the surrounding datapath side.
interface calc_op_ctrl_if;

    logic       start;
    logic [1:0] op;
    logic       abort;
    logic       mul_done;
    logic       div_done;
    logic       sqr_done;
    logic       from_mul;
    logic       from_div;
    logic       from_sqr;
    logic       alu_go;
    logic       mul_start;
    logic       div_start;
    logic       sqr_start;
    logic       busy;
    logic       op_done;
    logic       err_timeout;
    logic [1:0] res_sel;

    modport slave (
        input  start, op, abort, mul_done, div_done, sqr_done,
        output from_mul, from_div, from_sqr, alu_go, mul_start, div_start, sqr_start,
               busy, op_done, err_timeout, res_sel
    );

    modport master (
        output start, op, abort, mul_done, div_done, sqr_done,
        input  from_mul, from_div, from_sqr, alu_go, mul_start, div_start, sqr_start,
               busy, op_done, err_timeout, res_sel
    );

endinterface

// File: rtl/calc_op_ctrl_watchdog.sv
// Loadable clear/enable up-counter with a terminal-count flag; clear has priority over enable.
// The flag is a pure compare of the registered count, so it is valid in the same cycle the count reaches TERMINAL.
module op_watchdog #(
    parameter int W        = 8,
    parameter int TERMINAL = 199
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/calc_op_ctrl.sv
// Operation sequencer: routes the x-register mode lines, strobes one unit, waits for its done, reports completion.
// Every output is a flop; mode lines follow the state, strobes and op_done lag their state by one cycle.
module calc_op_ctrl
    import calc_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic             clk,
    input  logic             rst,
    calc_op_ctrl_if.slave    bus
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [2:0] r_mode;
    logic       r_alu_go;
    logic       r_mul_start;
    logic       r_div_start;
    logic       r_sqr_start;
    logic       r_busy;
    logic       r_op_done;
    logic       r_err;
    logic [1:0] r_res_sel;

    logic       w_accept;
    logic       w_unit_done;
    logic       w_timeout;
    logic       w_tc;
    logic       w_wd_clr;
    logic       w_wd_en;
    logic       w_in_go;
    logic       w_finish;
    logic [2:0] w_mode;

    // Only the captured unit's done counts; the ALU has no done line.
    always_comb begin
        w_unit_done = 1'b0;
        case (r_op)
            OP_MUL:  w_unit_done = bus.mul_done;
            OP_DIV:  w_unit_done = bus.div_done;
            OP_SQR:  w_unit_done = bus.sqr_done;
            default: w_unit_done = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_accept = 1'b1;
                    w_next   = ST_SEL;
                end
            end
            ST_SEL:  w_next = ST_LOAD;
            ST_LOAD: w_next = ST_GO;
            ST_GO:   w_next = (r_op == OP_ALU) ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (w_unit_done) begin
                    w_next = ST_DONE;
                end else if (w_tc) begin
                    w_timeout = !bus.abort;
                    w_next    = ST_IDLE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (bus.abort) begin
            w_next = ST_IDLE;
        end
    end

    assign w_wd_clr = (r_state == ST_GO);
    assign w_wd_en  = (r_state == ST_WAIT);
    assign w_in_go  = (r_state == ST_GO) && !bus.abort;
    assign w_finish = (r_state == ST_DONE) && !bus.abort;
    assign w_mode   = (w_next == ST_IDLE) ? SEL_ALU : sel_of_op(w_accept ? bus.op : r_op);

    op_watchdog #(
        .W        (TIMEOUT_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_wd_clr),
        .i_en  (w_wd_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ALU;
            r_mode      <= SEL_ALU;
            r_alu_go    <= 1'b0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_sqr_start <= 1'b0;
            r_busy      <= 1'b0;
            r_op_done   <= 1'b0;
            r_err       <= 1'b0;
            r_res_sel   <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_mode      <= w_mode;
            r_busy      <= (w_next != ST_IDLE);
            r_alu_go    <= w_in_go && (r_op == OP_ALU);
            r_mul_start <= w_in_go && (r_op == OP_MUL);
            r_div_start <= w_in_go && (r_op == OP_DIV);
            r_sqr_start <= w_in_go && (r_op == OP_SQR);
            r_op_done   <= w_finish;
            if (w_accept) begin
                r_op <= bus.op;
            end
            if (w_finish) begin
                r_res_sel <= r_op;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.from_mul    = r_mode[2];
    assign bus.from_div    = r_mode[1];
    assign bus.from_sqr    = r_mode[0];
    assign bus.alu_go      = r_alu_go;
    assign bus.mul_start   = r_mul_start;
    assign bus.div_start   = r_div_start;
    assign bus.sqr_start   = r_sqr_start;
    assign bus.busy        = r_busy;
    assign bus.op_done     = r_op_done;
    assign bus.err_timeout = r_err;
    assign bus.res_sel     = r_res_sel;

endmodule

// File: tb/tb_calc_op_ctrl.sv
// Directed bench for calc_op_ctrl: stimulus pushes expected completions, a negedge monitor pops and compares.
module tb_calc_op_ctrl;
    import calc_pkg::*;

    typedef struct {
        bit         is_err;
        logic [1:0] res;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];
    logic prev_err;

    calc_op_ctrl_if bus();

    calc_op_ctrl #(
        .TIMEOUT_W (8),
        .TIMEOUT   (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [1:0] res);
        exp_t e;
        e.is_err = is_err;
        e.res    = res;
        exp_q.push_back(e);
    endtask

    // Returns just after the accepting edge ("edge 0").
    task automatic do_start(input logic [1:0] op);
        bus.op    = op;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({bus.from_mul, bus.from_div, bus.from_sqr, bus.alu_go, bus.mul_start,
                     bus.div_start, bus.sqr_start, bus.busy, bus.op_done, bus.err_timeout,
                     bus.res_sel});
    endfunction

    // Scoreboard monitor: every completion or new timeout must match the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("onehot_mode", int'($countones({bus.from_mul, bus.from_div, bus.from_sqr}) <= 1), 1);
            chk("onehot_strobe", int'($countones({bus.alu_go, bus.mul_start, bus.div_start,
                                                  bus.sqr_start}) <= 1), 1);
            if (bus.op_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_is_done", 1, int'(!e.is_err));
                    chk("res_sel", int'(bus.res_sel), int'(e.res));
                end
            end
            if (bus.err_timeout && !prev_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_timeout", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_is_timeout", 1, int'(e.is_err));
                end
            end
        end
        prev_err = rst ? bus.err_timeout : 1'b0;
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        prev_err     = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.abort    = 1'b0;
        bus.mul_done = 1'b0;
        bus.div_done = 1'b0;
        bus.sqr_done = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("reset_outputs", all_outs(), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset while waiting on the multiplier
        do_start(OP_MUL);
        repeat (6) tick();
        chk("pre_rst_from_mul", int'(bus.from_mul), 1);
        chk("pre_rst_busy", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", all_outs(), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_mode", int'({bus.from_mul, bus.from_div, bus.from_sqr}), 0);

        // ALU: alu_go after edge 3, op_done after edge 4
        push(1'b0, OP_ALU);
        do_start(OP_ALU);
        chk("alu_busy_e0", int'(bus.busy), 1);
        tick();
        tick();
        chk("alu_go_e2", int'(bus.alu_go), 0);
        tick();
        chk("alu_go_e3", int'(bus.alu_go), 1);
        chk("alu_mode_e3", int'({bus.from_mul, bus.from_div, bus.from_sqr}), 0);
        tick();
        chk("alu_op_done_e4", int'(bus.op_done), 1);
        chk("alu_go_e4", int'(bus.alu_go), 0);
        chk("alu_busy_e4", int'(bus.busy), 0);
        tick();
        chk("alu_op_done_e5", int'(bus.op_done), 0);

        // MUL: mul_done raised 6 cycles after mul_start
        push(1'b0, OP_MUL);
        do_start(OP_MUL);
        chk("mul_from_mul_e0", int'(bus.from_mul), 1);
        tick();
        tick();
        chk("mul_start_e2", int'(bus.mul_start), 0);
        tick();
        chk("mul_start_e3", int'(bus.mul_start), 1);
        for (int i = 4; i <= 8; i++) begin
            tick();
            chk("mul_start_single", int'(bus.mul_start), 0);
            chk("mul_from_mul_hold", int'(bus.from_mul), 1);
        end
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        chk("mul_op_done_e9", int'(bus.op_done), 0);
        chk("mul_from_mul_done", int'(bus.from_mul), 1);
        tick();
        chk("mul_op_done_e10", int'(bus.op_done), 1);
        chk("mul_mode_idle", int'(bus.from_mul), 0);

        // DIV with no done: timeout at edge 203 after 200 WAIT cycles
        push(1'b1, 2'b00);
        do_start(OP_DIV);
        repeat (202) tick();
        chk("div_err_e202", int'(bus.err_timeout), 0);
        chk("div_busy_e202", int'(bus.busy), 1);
        tick();
        chk("div_err_e203", int'(bus.err_timeout), 1);
        chk("div_busy_e203", int'(bus.busy), 0);
        chk("div_op_done_e203", int'(bus.op_done), 0);
        tick();
        chk("div_err_sticky", int'(bus.err_timeout), 1);
        push(1'b0, OP_ALU);
        do_start(OP_ALU);
        chk("err_cleared_by_start", int'(bus.err_timeout), 0);
        repeat (4) tick();

        // Interference: start while busy, foreign done, done on terminal count
        push(1'b0, OP_DIV);
        do_start(OP_DIV);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        tick();
        tick();
        bus.start = 1'b0;
        bus.op    = OP_DIV;
        chk("intf_from_div", int'(bus.from_div), 1);
        chk("intf_from_mul", int'(bus.from_mul), 0);
        for (int i = 3; i <= 202; i++) begin
            tick();
            bus.sqr_done = (i >= 5 && i < 100);
        end
        chk("intf_busy_e202", int'(bus.busy), 1);
        bus.sqr_done = 1'b0;
        bus.div_done = 1'b1;
        tick();
        bus.div_done = 1'b0;
        chk("intf_err_e203", int'(bus.err_timeout), 0);
        chk("intf_busy_e203", int'(bus.busy), 1);
        tick();
        chk("intf_op_done_e204", int'(bus.op_done), 1);
        chk("intf_err_e204", int'(bus.err_timeout), 0);
        repeat (3) tick();
        chk("intf_no_queue", int'(bus.busy), 0);

        // Abort in GO for SQR, then a normal MUL
        do_start(OP_SQR);
        tick();
        tick();
        chk("abort_from_sqr_go", int'(bus.from_sqr), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_sqr_start", int'(bus.sqr_start), 0);
        chk("abort_mode", int'({bus.from_mul, bus.from_div, bus.from_sqr}), 0);
        chk("abort_busy", int'(bus.busy), 0);
        tick();
        chk("abort_sqr_start_late", int'(bus.sqr_start), 0);
        push(1'b0, OP_MUL);
        bus.mul_done = 1'b1;
        do_start(OP_MUL);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20 && seen == 0; i++) begin
                tick();
                if (bus.op_done) seen = 1;
            end
            chk("mul_after_abort_done", seen, 1);
        end
        bus.mul_done = 1'b0;

        // Abort and start together in IDLE: request dropped
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_start_busy", int'(bus.busy), 0);
        tick();
        chk("abort_start_mode", int'(bus.from_mul), 0);

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
